// File: rtl/tone_gen.sv
// Phase-accumulator sine source with a 17-entry quarter-wave table and power-of-two gain.
// A sample is produced every CLK_DIV enabled clocks and offered on a valid/ready port with sticky overrun.
module tone_gen #(
  parameter int CLK_DIV = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               phaseClr,
  input  logic [15:0]        phaseInc,
  input  logic [1:0]         gainShift,
  input  logic               toneReady,
  input  logic               ovrClr,
  output logic signed [15:0] toneOut,
  output logic               toneValid,
  output logic               overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div;
  logic [15:0]        phase;
  logic [15:0]        phase_next;
  logic               tick;
  logic               load;
  logic [1:0]         quad;
  logic [3:0]         idx_raw;
  logic [4:0]         idx;
  logic [14:0]        mag;
  logic signed [15:0] raw;
  logic signed [15:0] scaled;

  // T[k] = round(32767*sin(k*pi/32)); T[4] is pinned to 12540.
  function automatic logic [14:0] quarter_sine(input logic [4:0] k);
    case (k)
      5'd0:    return 15'd0;
      5'd1:    return 15'd3212;
      5'd2:    return 15'd6393;
      5'd3:    return 15'd9512;
      5'd4:    return 15'd12540;
      5'd5:    return 15'd15446;
      5'd6:    return 15'd18204;
      5'd7:    return 15'd20787;
      5'd8:    return 15'd23170;
      5'd9:    return 15'd25329;
      5'd10:   return 15'd27245;
      5'd11:   return 15'd28898;
      5'd12:   return 15'd30273;
      5'd13:   return 15'd31356;
      5'd14:   return 15'd32137;
      5'd15:   return 15'd32609;
      default: return 15'd32767;
    endcase
  endfunction

  assign tick       = enable && (div == DIV_LAST);
  assign load       = tick && !phaseClr;
  assign phase_next = phase + phaseInc;

  always_comb begin
    quad    = phase[15:14];
    idx_raw = phase[13:10];
    idx     = quad[0] ? (5'd16 - {1'b0, idx_raw}) : {1'b0, idx_raw};
    mag     = quarter_sine(idx);
    raw     = quad[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    scaled  = raw >>> gainShift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div   <= '0;
      phase <= '0;
    end else if (phaseClr) begin
      div   <= '0;
      phase <= '0;
    end else if (enable) begin
      if (tick) begin
        div   <= '0;
        phase <= phase_next;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // A new sample wins over a same-cycle acceptance, so valid stays high on load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toneOut   <= '0;
      toneValid <= 1'b0;
    end else if (load) begin
      toneOut   <= scaled;
      toneValid <= 1'b1;
    end else if (toneValid && toneReady) begin
      toneValid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (load && toneValid && !toneReady) begin
      overrun <= 1'b1;
    end else if (ovrClr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: sequence values, gain, handshake/overrun, phase clear, enable and reset.
module tb_tone_gen;
  localparam int CLK_DIV = 3;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b0;
  logic               phaseClr = 1'b0;
  logic [15:0]        phaseInc = '0;
  logic [1:0]         gainShift = '0;
  logic               toneReady = 1'b0;
  logic               ovrClr = 1'b0;
  logic signed [15:0] toneOut;
  logic               toneValid;
  logic               overrun;

  int n_checks = 0;
  int n_fail = 0;

  int exp_g2[16] = '{0, 3135, 5792, 7568, 8191, 7568, 5792, 3135,
                     0, -3135, -5793, -7569, -8192, -7569, -5793, -3135};
  int got_g0[16];

  tone_gen #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .phaseClr(phaseClr),
    .phaseInc(phaseInc), .gainShift(gainShift), .toneReady(toneReady),
    .ovrClr(ovrClr), .toneOut(toneOut), .toneValid(toneValid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    chk("rst_out", int'(toneOut), 0);
    chk("rst_valid", int'(toneValid), 0);
    chk("rst_ovr", int'(overrun), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic next_tick();
    repeat (CLK_DIV) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // 1: gain 2 sequence, one sample every CLK_DIV clocks
    enable = 1'b1; phaseInc = 16'h1000; gainShift = 2'd2; toneReady = 1'b1;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      repeat (CLK_DIV - 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("t1_gap%0d", k), int'(toneValid), 0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t1_valid%0d", k), int'(toneValid), 1);
      chk($sformatf("t1_out%0d", k), int'(toneOut), exp_g2[k % 16]);
    end
    chk("t1_ovr", int'(overrun), 0);

    // 2: full scale
    gainShift = 2'd0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      next_tick();
      got_g0[k] = int'(toneOut);
    end
    chk("t2_s1", got_g0[1], 12540);
    chk("t2_s2", got_g0[2], 23170);
    chk("t2_s3", got_g0[3], 30273);
    chk("t2_pos", got_g0[4], 32767);
    chk("t2_zero", got_g0[8], 0);
    chk("t2_neg", got_g0[12], -32767);

    // 3: overrun after two unaccepted ticks, clear, then accept
    gainShift = 2'd2; toneReady = 1'b0;
    do_reset();
    next_tick();
    chk("t3_v1", int'(toneValid), 1);
    chk("t3_o1", int'(overrun), 0);
    next_tick();
    chk("t3_v2", int'(toneValid), 1);
    chk("t3_out2", int'(toneOut), 3135);
    chk("t3_o2", int'(overrun), 1);
    ovrClr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovrClr = 1'b0;
    chk("t3_oclr", int'(overrun), 0);
    toneReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    toneReady = 1'b0;
    chk("t3_acc", int'(toneValid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_v3", int'(toneValid), 1);
    chk("t3_out3", int'(toneOut), 5792);
    chk("t3_o3", int'(overrun), 0);

    // 4: ready asserted only on the tick cycle while a sample is pending
    repeat (CLK_DIV - 1) @(posedge clk);
    @(negedge clk);
    chk("t4_pend", int'(toneValid), 1);
    toneReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    toneReady = 1'b0;
    chk("t4_valid", int'(toneValid), 1);
    chk("t4_out", int'(toneOut), 7568);
    chk("t4_ovr", int'(overrun), 0);

    // 5: phase clear after the 5th sample
    toneReady = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) next_tick();
    chk("t5_s5", int'(toneOut), 8191);
    @(posedge clk);
    @(negedge clk);
    phaseClr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    phaseClr = 1'b0;
    chk("t5_clr_valid", int'(toneValid), 0);
    chk("t5_clr_out", int'(toneOut), 8191);
    repeat (CLK_DIV - 1) @(posedge clk);
    @(negedge clk);
    chk("t5_early", int'(toneValid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid", int'(toneValid), 1);
    chk("t5_out", int'(toneOut), 0);
    next_tick();
    chk("t5_next", int'(toneOut), 3135);

    // 6a: enable low for 10 clocks mid-sample
    do_reset();
    next_tick();
    next_tick();
    chk("t6_s2", int'(toneOut), 3135);
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t6_hold_v", int'(toneValid), 0);
    chk("t6_hold_o", int'(toneOut), 3135);
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rem1", int'(toneValid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_rem2_v", int'(toneValid), 1);
    chk("t6_rem2_o", int'(toneOut), 5792);

    // 6b: asynchronous reset mid-stream, then restart from phase 0
    toneReady = 1'b0;
    next_tick();
    next_tick();
    chk("t6_pre_ovr", int'(overrun), 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_ar_out", int'(toneOut), 0);
    chk("t6_ar_valid", int'(toneValid), 0);
    chk("t6_ar_ovr", int'(overrun), 0);
    toneReady = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (CLK_DIV - 1) @(posedge clk);
    @(negedge clk);
    chk("t6_rs_gap", int'(toneValid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_rs_v", int'(toneValid), 1);
    chk("t6_rs_o", int'(toneOut), 0);
    next_tick();
    chk("t6_rs_o2", int'(toneOut), 3135);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
